relu_bound_pipe: RTL

RELU_BOUND_PIPE -- requirements
Module: relu_bound_pipe

---
 rtl/relu_bound_pipe.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/relu_bound_pipe.sv
// ---------------------------------------------------------------------------
// relu_bound_pipe
//   Two-stage requantisation pipe for CH parallel channels of signed
//   accumulator+bias values.
//     S1: per-channel rounding right shift (round half up, arithmetic),
//         evaluated one bit wider than the input so the rounding add never
//         overflows.
//     S2: clamp to [lo, hi] where lo is max(i_min, 0) in ReLU mode, and
//         flag every channel that was clamped.
//   Both stages are valid/ready elastic. Throughput is one beat per cycle,
//   and latency is two cycles when the output is not stalled.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   i_valid         input beat valid
//   o_ready_in      block can take an input beat (combinational from i_ready_out)
//   i_acc_bias      CH signed AB_BW values, channel k at [k*AB_BW +: AB_BW]
//   i_shift         unsigned right-shift amount (sampled with the beat)
//   i_min, i_max    signed clamp bounds (sampled with the beat)
//   i_relu_en       ReLU mode (sampled with the beat)
//   o_valid         output beat valid
//   i_ready_out     downstream accepts the output beat
//   o_bound_data    CH signed D_BW results, channel k at [k*D_BW +: D_BW]
//   o_sat           per-channel "value was clamped" flags
//
// Optional feature (macro BOUND_SAT_CNT_EN)
//   i_cnt_clr       synchronous clear of the saturation counter (beats increment)
//   o_sat_cnt       16-bit saturating count of clamped channels over all
//                   output transfers
// ---------------------------------------------------------------------------
module relu_bound_pipe #(
  parameter int D_BW  = 8,
  parameter int AB_BW = 21,
  parameter int CH    = 4,
  parameter int SH_BW = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready_in,
  input  logic [CH*AB_BW-1:0]      i_acc_bias,
  input  logic [SH_BW-1:0]         i_shift,
  input  logic signed [D_BW-1:0]   i_min,
  input  logic signed [D_BW-1:0]   i_max,
  input  logic                     i_relu_en,
  output logic                     o_valid,
  input  logic                     i_ready_out,
  output logic [CH*D_BW-1:0]       o_bound_data,
  output logic [CH-1:0]            o_sat
`ifdef BOUND_SAT_CNT_EN
  ,
  input  logic                     i_cnt_clr,
  output logic [15:0]              o_sat_cnt
`endif
);

  // Rounding arithmetic right shift in AB_BW+1 bits. Shifts of AB_BW or more
  // collapse to the sign: 0 for non-negative, -1 for negative inputs.
  function automatic logic signed [AB_BW:0] shift_round(
    input logic signed [AB_BW-1:0] x,
    input logic [SH_BW-1:0]        sh
  );
    logic signed [AB_BW:0] xe;
    logic signed [AB_BW:0] one;
    logic signed [AB_BW:0] rc;
    logic [SH_BW-1:0]      sm1;
    xe  = {x[AB_BW-1], x};
    one = {{AB_BW{1'b0}}, 1'b1};
    if (sh == {SH_BW{1'b0}}) begin
      shift_round = xe;
    end else if (int'(sh) >= AB_BW) begin
      shift_round = x[AB_BW-1] ? {(AB_BW+1){1'b1}} : {(AB_BW+1){1'b0}};
    end else begin
      sm1 = sh - {{(SH_BW-1){1'b0}}, 1'b1};
      rc  = one << sm1;
      shift_round = (xe + rc) >>> sh;
    end
  endfunction

  // Number of set flags in one beat's saturation vector.
  function automatic logic [15:0] popcount(input logic [CH-1:0] v);
    logic [15:0] n;
    n = 16'd0;
    for (int k = 0; k < CH; k++) begin
      n = n + {15'd0, v[k]};
    end
    popcount = n;
  endfunction

  // Handshake signals
  logic                  s1_valid_r;
  logic                  s2_load_s;
  logic                  s1_adv_s;
  logic                  in_fire_s;

  // S1 state: shifted value per channel plus the bounds that travel with it
  logic signed [AB_BW:0] s1_r_s [CH];
  logic signed [AB_BW:0] s1_r_r [CH];
  logic signed [D_BW-1:0] s1_min_r;
  logic signed [D_BW-1:0] s1_max_r;
  logic                   s1_relu_r;

  // S2 combinational clamp results
  logic signed [D_BW-1:0]  lo_d_s;
  logic signed [AB_BW:0]   lo_e_s;
  logic signed [AB_BW:0]   hi_e_s;
  logic [CH-1:0][D_BW-1:0] s2_data_s;
  logic [CH-1:0]           s2_sat_s;

  // S2 refills when empty or draining; S1 advances only into a refilling S2.
  assign s2_load_s  = !o_valid | i_ready_out;
  assign s1_adv_s   = s1_valid_r & s2_load_s;
  assign o_ready_in = !s1_valid_r | s1_adv_s;
  assign in_fire_s  = i_valid & o_ready_in;

  // S1 combinational rounding shift per channel
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      s1_r_s[k] = shift_round(i_acc_bias[k*AB_BW +: AB_BW], i_shift);
    end
  end

  // S1 pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        s1_r_r[k] <= {(AB_BW+1){1'b0}};
      end
      s1_min_r  <= {D_BW{1'b0}};
      s1_max_r  <= {D_BW{1'b0}};
      s1_relu_r <= 1'b0;
    end else if (in_fire_s) begin
      s1_valid_r <= 1'b1;
      for (int k = 0; k < CH; k++) begin
        s1_r_r[k] <= s1_r_s[k];
      end
      s1_min_r  <= i_min;
      s1_max_r  <= i_max;
      s1_relu_r <= i_relu_en;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // S2 combinational clamp. Lower bound is tested first, so an inverted
  // range (lo > hi) sends low values to lo and everything else to hi.
  always_comb begin
    lo_d_s    = (s1_relu_r && s1_min_r[D_BW-1]) ? {D_BW{1'b0}} : s1_min_r;
    lo_e_s    = {{(AB_BW+1-D_BW){lo_d_s[D_BW-1]}}, lo_d_s};
    hi_e_s    = {{(AB_BW+1-D_BW){s1_max_r[D_BW-1]}}, s1_max_r};
    s2_data_s = {(CH*D_BW){1'b0}};
    s2_sat_s  = {CH{1'b0}};
    for (int k = 0; k < CH; k++) begin
      if (s1_r_r[k] < lo_e_s) begin
        s2_data_s[k] = lo_d_s;
        s2_sat_s[k]  = 1'b1;
      end else if (s1_r_r[k] > hi_e_s) begin
        s2_data_s[k] = s1_max_r;
        s2_sat_s[k]  = 1'b1;
      end else begin
        s2_data_s[k] = s1_r_r[k][D_BW-1:0];
        s2_sat_s[k]  = 1'b0;
      end
    end
  end

  // S2 output register; data only changes when a real beat moves in, so
  // outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid      <= 1'b0;
      o_bound_data <= {(CH*D_BW){1'b0}};
      o_sat        <= {CH{1'b0}};
    end else if (s2_load_s) begin
      o_valid <= s1_valid_r;
      if (s1_valid_r) begin
        o_bound_data <= s2_data_s;
        o_sat        <= s2_sat_s;
      end
    end
  end

`ifdef BOUND_SAT_CNT_EN
  logic [16:0] cnt_sum_s;
  logic [15:0] cnt_next_s;

  // Saturating increment by the number of clamped channels in the transfer
  always_comb begin
    cnt_sum_s = {1'b0, o_sat_cnt} + {1'b0, popcount(o_sat)};
    if (cnt_sum_s[16]) begin
      cnt_next_s = 16'hFFFF;
    end else begin
      cnt_next_s = cnt_sum_s[15:0];
    end
  end

  // Saturation counter register; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sat_cnt <= 16'd0;
    end else if (i_cnt_clr) begin
      o_sat_cnt <= 16'd0;
    end else if (o_valid && i_ready_out) begin
      o_sat_cnt <= cnt_next_s;
    end
  end
`else
`endif

endmodule
